// File: rtl/div_pkg.sv
// Shared definitions for the divider scheduler.
//   state_t        : scheduler FSM states
//   REQ0 / REQ1    : requester identifiers carried on resp_id
//   is_div_special : flags operand pairs the scheduler resolves without the divider
package div_pkg;

    localparam int DIV_W = 64;
    localparam logic [DIV_W-1:0] DIV_MIN = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Returns {dz, ovf}. Divide-by-zero wins if both could apply.
    function automatic logic [1:0] is_div_special(input logic [DIV_W-1:0] a,
                                                  input logic [DIV_W-1:0] b);
        logic dz;
        logic ovf;
        dz  = (b == '0);
        ovf = !dz && (a == DIV_MIN) && (b == '1);
        return {dz, ovf};
    endfunction

endpackage

// File: rtl/divider.sv
// Combinational signed divider shared by the scheduler.
//   a, b : signed dividend / divisor
//   quo  : quotient truncated toward zero
//   r    : remainder, sign follows dividend
//   ovf  : MIN / -1 overflow flag
module divider #(
    parameter int WIDTH = 64
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] quo,
    output logic signed [WIDTH-1:0] r,
    output logic                    ovf
);
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        ovf = 1'b0;
        quo = '1;
        r   = a;
        if (b != '0) begin
            if (a == MIN_V && b == '1) begin
                ovf = 1'b1;
                quo = a;
                r   = '0;
            end else begin
                quo = a / b;
                r   = a % b;
            end
        end
    end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   valid_i : request lines
//   adv_i   : grant was taken this cycle; move priority to the other side
//   grant_o : one-hot grant (combinational)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       adv_i,
    output logic [1:0] grant_o
);
    logic rr_ptr_q;

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // Point at whichever requester was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rr_ptr_q <= 1'b0;
        else if (adv_i) rr_ptr_q <= grant_o[0];
    end
endmodule

// File: rtl/div_scheduler.sv
// Shares one combinational divider between two requesters.
// Operands are registered, the divider is given SETTLE_CYCLES to settle,
// and the result is returned on a valid/ready channel tagged with the
// requester id. Divide-by-zero and MIN/-1 are answered directly.
//   req0_* / req1_* : valid/ready request channels with signed operands
//   resp_*          : response channel (quotient, remainder, flags, id)
//   busy            : an operation is in flight
module div_scheduler
    import div_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic signed [WIDTH-1:0] req0_a,
    input  logic signed [WIDTH-1:0] req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic signed [WIDTH-1:0] req1_a,
    input  logic signed [WIDTH-1:0] req1_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_id,
    output logic signed [WIDTH-1:0] resp_quo,
    output logic signed [WIDTH-1:0] resp_rem,
    output logic                    resp_ovf,
    output logic                    resp_dz,
    output logic                    busy
);
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic signed [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic                    id_q, id_d, ovf_q, ovf_d, dz_q, dz_d;

    logic [1:0]              grant;
    logic                    accept;
    logic signed [WIDTH-1:0] in_a, in_b;
    logic [1:0]              special;
    logic signed [WIDTH-1:0] div_quo, div_rem;
    logic                    div_ovf_unused;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i ({req1_valid, req0_valid}),
        .adv_i   (accept),
        .grant_o (grant)
    );

    // Divider sees only the latched operands so its inputs are stable
    // for the whole settle window.
    divider #(.WIDTH(WIDTH)) d0 (
        .a   (a_q),
        .b   (b_q),
        .quo (div_quo),
        .r   (div_rem),
        .ovf (div_ovf_unused)
    );

    assign accept     = (state_q == IDLE) && (grant != 2'b00);
    assign req0_ready = (state_q == IDLE) && grant[0];
    assign req1_ready = (state_q == IDLE) && grant[1];
    assign in_a       = grant[1] ? req1_a : req0_a;
    assign in_b       = grant[1] ? req1_b : req0_b;
    assign special    = is_div_special(in_a, in_b);

    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_quo   = quo_q;
    assign resp_rem   = rem_q;
    assign resp_ovf   = ovf_q;
    assign resp_dz    = dz_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d  = in_a;
                    b_d  = in_b;
                    id_d = grant[1] ? REQ1 : REQ0;
                    if (special[1]) begin
                        quo_d   = '1;
                        rem_d   = in_a;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = RESP;
                    end else if (special[0]) begin
                        quo_d   = in_a;  // in_a is MIN here
                        rem_d   = '0;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    quo_d   = div_quo;
                    rem_d   = div_rem;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_div_scheduler.sv
module tb_div_scheduler;
    localparam int W  = 64;
    localparam int SC = 2;
    localparam logic signed [W-1:0] MINV = 64'sh8000_0000_0000_0000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req0_valid, req0_ready, req1_valid, req1_ready;
    logic signed [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic                resp_valid, resp_ready, resp_id, resp_ovf, resp_dz, busy;
    logic signed [W-1:0] resp_quo, resp_rem;

    div_scheduler #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quo(resp_quo), .resp_rem(resp_rem), .resp_ovf(resp_ovf), .resp_dz(resp_dz),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                id;
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic signed [W-1:0] quo;
        logic signed [W-1:0] rem;
        logic                ovf;
        logic                dz;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic id, input logic signed [W-1:0] a, b, q, r,
                                input logic ovf, dz);
        vec_t v;
        v.id = id; v.a = a; v.b = b; v.quo = q; v.rem = r; v.ovf = ovf; v.dz = dz;
        return v;
    endfunction

    // Drive a request, wait (bounded) for its ready, push expectation on accept.
    task automatic issue(input vec_t v, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        if (v.id) begin req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; end
        else      begin req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; end
        while (!got && waited < 40) begin
            @(negedge clk);
            waited++;
            if (v.id ? req1_ready : req0_ready) got = 1'b1;
        end
        chk("accept_seen", {63'd0, got}, 64'd1);
        if (got) begin
            sb.push_back(v);
            @(posedge clk);
            #1;
        end
        if (v.id) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    // Called right after the accept edge; checks latency and result, then handshakes.
    task automatic collect(input int exp_lat);
        int   lat;
        logic seen;
        vec_t e;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp_valid) seen = 1'b1;
        end
        chk("resp_seen", {63'd0, seen}, 64'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_id",  {63'd0, resp_id},  {63'd0, e.id});
            chk("resp_quo", resp_quo, e.quo);
            chk("resp_rem", resp_rem, e.rem);
            chk("resp_ovf", {63'd0, resp_ovf}, {63'd0, e.ovf});
            chk("resp_dz",  {63'd0, resp_dz},  {63'd0, e.dz});
            if (exp_lat > 0) chk("resp_latency", 64'(lat), 64'(exp_lat));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int lat_of(input vec_t v);
        return (v.ovf || v.dz) ? 1 : SC + 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   held;
        vec_t v0, v1;
        vecs[0] = mk(1'b0, 64'sd8,         64'sd2,      64'sd4,    64'sd0,     1'b0, 1'b0);
        vecs[1] = mk(1'b1, -64'sd78443,    64'sd799,    -64'sd98,  -64'sd141,  1'b0, 1'b0);
        vecs[2] = mk(1'b1, 64'sd34287624,  -64'sd75439, -64'sd454, 64'sd38318, 1'b0, 1'b0);
        vecs[3] = mk(1'b0, 64'sd9,         64'sd0,      -64'sd1,   64'sd9,     1'b0, 1'b1);
        vecs[4] = mk(1'b0, MINV,           -64'sd1,     MINV,      64'sd0,     1'b1, 1'b0);
        vecs[5] = mk(1'b1, -64'sd7,        64'sd2,      -64'sd3,   -64'sd1,    1'b0, 1'b0);
        vecs[6] = mk(1'b0, 64'sd7,         -64'sd2,     -64'sd3,   64'sd1,     1'b0, 1'b0);
        vecs[7] = mk(1'b1, MINV,           64'sd1,      MINV,      64'sd0,     1'b0, 1'b0);
        vecs[8] = mk(1'b1, -64'sd1,        64'sd0,      -64'sd1,   -64'sd1,    1'b0, 1'b1);
        vecs[9] = mk(1'b0, MINV,           64'sd0,      -64'sd1,   MINV,       1'b0, 1'b1);

        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;

        // Reset state
        #2;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy",       {63'd0, busy},       64'd0);
        chk("rst_resp_quo",   resp_quo,            64'd0);
        chk("rst_resp_id",    {63'd0, resp_id},    64'd0);
        chk("rst_flags",      {62'd0, resp_ovf, resp_dz}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i], w);
            if (i == 0) chk("first_ready_wait", 64'(w), 64'd1);
            collect(lat_of(vecs[i]));
        end

        // Simultaneous requests after a fresh reset: req0 wins, then req1, then req0 again
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        v0 = mk(1'b0, 64'sd9, 64'sd2, 64'sd4, 64'sd1, 1'b0, 1'b0);
        v1 = mk(1'b1, -64'sd534224, -64'sd9799, 64'sd54, -64'sd5078, 1'b0, 1'b0);
        req0_valid = 1'b1; req0_a = v0.a; req0_b = v0.b;
        req1_valid = 1'b1; req1_a = v1.a; req1_b = v1.b;
        @(negedge clk);
        chk("sim_req0_ready", {63'd0, req0_ready}, 64'd1);
        chk("sim_req1_ready", {63'd0, req1_ready}, 64'd0);
        sb.push_back(v0);
        @(posedge clk); #1 req0_valid = 1'b0;
        collect(SC + 1);
        issue(v1, w);
        chk("sim_req1_wait", 64'(w), 64'd1);
        collect(SC + 1);
        v0 = mk(1'b0, 64'sd100, 64'sd7, 64'sd14, 64'sd2, 1'b0, 1'b0);
        v1 = mk(1'b1, -64'sd100, 64'sd7, -64'sd14, -64'sd2, 1'b0, 1'b0);
        req0_valid = 1'b1; req0_a = v0.a; req0_b = v0.b;
        req1_valid = 1'b1; req1_a = v1.a; req1_b = v1.b;
        @(negedge clk);
        chk("rr_req0_ready", {63'd0, req0_ready}, 64'd1);
        chk("rr_req1_ready", {63'd0, req1_ready}, 64'd0);
        sb.push_back(v0);
        @(posedge clk); #1 req0_valid = 1'b0;
        collect(SC + 1);
        issue(v1, w);
        collect(SC + 1);

        // Backpressure: response held for 5 cycles with another requester waiting
        resp_ready = 1'b0;
        v0 = mk(1'b0, -64'sd55, 64'sd4, -64'sd13, -64'sd3, 1'b0, 1'b0);
        issue(v0, w);
        req1_valid = 1'b1; req1_a = 64'sd5; req1_b = 64'sd5;
        held = 0;
        while (!resp_valid && held < 40) begin @(negedge clk); held++; end
        chk("bp_resp_seen", {63'd0, resp_valid}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid",  {63'd0, resp_valid}, 64'd1);
            chk("bp_quo",    resp_quo, v0.quo);
            chk("bp_rem",    resp_rem, v0.rem);
            chk("bp_busy",   {63'd0, busy}, 64'd1);
            chk("bp_readys", {62'd0, req0_ready, req1_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        if (sb.size() > 0) v1 = sb.pop_front();
        chk("bp_done_valid", {63'd0, resp_valid}, 64'd0);
        chk("bp_done_busy",  {63'd0, busy}, 64'd0);

        // Asynchronous reset during SETTLE
        v0 = mk(1'b0, 64'sd1000, 64'sd3, 64'sd333, 64'sd1, 1'b0, 1'b0);
        issue(v0, w);
        chk("mid_in_settle", {63'd0, busy}, 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
        chk("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("mid_rst_quo",   resp_quo, 64'd0);
        if (sb.size() > 0) v1 = sb.pop_front();
        @(posedge clk); #1 rst_n = 1'b1;
        held = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) held++;
        end
        chk("mid_no_resp", 64'(held), 64'd0);
        v0 = mk(1'b0, 64'sd42398284, 64'sd54389, 64'sd779, 64'sd29253, 1'b0, 1'b0);
        issue(v0, w);
        collect(SC + 1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
Shares one instance of the team's combinational 64-bit signed `divider` (ports a, b, quo, r, ovf) between two requesters. Operands are latched into registers, and the divider output is held for a configurable multicycle settle window before capture. The result is returned over a valid/ready response channel with the requester ID. Divide-by-zero and signed overflow are resolved locally without waiting out the settle window.

Parameters:
WIDTH, 64, operand/result width; must match divider width.
SETTLE_CYCLES, 2, cycles the divider inputs are held stable before result capture; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  WIDTH  requester 0 dividend, signed
req0_b  input  WIDTH  requester 0 divisor, signed
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accepted this cycle
req1_a  input  WIDTH  requester 1 dividend, signed
req1_b  input  WIDTH  requester 1 divisor, signed
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_id  output  1  requester that owns the result
resp_quo  output  WIDTH  signed quotient, truncated toward zero
resp_rem  output  WIDTH  signed remainder; sign follows dividend
resp_ovf  output  1  signed overflow case
resp_dz  output  1  divide-by-zero case
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, SETTLE, RESP. Only one operation is in flight; there is no queue.
- Reset (async, any state): state=IDLE; rr_ptr=0; counter=0; operand and result registers=0; resp_valid=0, resp_id=0, resp_ovf=0, resp_dz=0, busy=0. An in-flight operation is discarded and no response is produced.
- reqX_ready is combinational: state==IDLE && grant==X. At most one ready is high per cycle.
- Grant in IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester rr_ptr names.
  - On a grant, rr_ptr updates to the other requester.
- Accept edge (IDLE, grant valid): latch a, b and id.
  - Special cases are checked on the incoming operands:
    - b==0: result quo=all-ones, rem=a, dz=1, ovf=0. Next state RESP.
    - a==signed MIN and b==-1: result quo=MIN, rem=0, ovf=1, dz=0. Next state RESP.
  - Otherwise: counter=SETTLE_CYCLES-1, next state SETTLE.
- Special-case results are written straight into the result registers, so resp_valid rises 1 cycle after accept.
- The divider instance is driven only from the latched operand registers, never from request ports.
- SETTLE:
  - Decrement the counter each cycle.
  - At the edge where the counter is 0, capture divider quo and r into the result registers, set ovf=0 and dz=0, and go to RESP.
  - Normal latency: resp_valid rises SETTLE_CYCLES+1 cycles after the accept edge.
- RESP:
  - resp_valid=1. resp_* stays stable until resp_ready is sampled high.
  - On handshake, go to IDLE. A new request can be accepted the next cycle, so there is no back-to-back bypass.
- Requests arriving while busy wait with valid held. Requesters must keep operands stable until ready.
- Width rules:
  - All arithmetic is two's complement at WIDTH.
  - The counter is 4 bits.
  - rr_ptr is 1 bit.
- Divider ovf: the divider's own ovf output is ignored. resp_ovf comes only from the scheduler's own detection.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, SETTLE, RESP}
  - requester ID constants REQ0=0, REQ1=1
  - function is_div_special returning {dz, ovf} from a, b
- Sub-module rr_arb2: 2-way round-robin arbiter with rr_ptr register, valid inputs, one-hot grant, and an advance-on-accept input.
- The existing `divider` is instantiated unmodified as d0.

Test Plan:
- Single request: after reset, req0 a=8 b=2, resp_ready=1 -> req0_ready on first cycle; resp_valid exactly 3 cycles after accept (SETTLE_CYCLES=2); quo=4, rem=0, id=0, ovf=0, dz=0.
- Signed operands, sequential on req1: a=-78443 b=799 -> quo=-98, rem=-141; then a=34287624 b=-75439 -> quo=-454, rem=38318.
- Simultaneous requests: req0 (9,2) and req1 (-534224,-9799) valid in the same cycle right after reset -> req0 served first (quo=4, rem=1, id=0); req1 next (quo=54, rem=-5078, id=1); rr_ptr then favours req0.
- Special cases:
  - a=9 b=0 -> resp_valid 1 cycle after accept; quo=all-ones, rem=9, dz=1.
  - a=0x8000_0000_0000_0000 b=-1 -> quo=0x8000_0000_0000_0000, rem=0, ovf=1.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_* constant, busy=1, both reqX_ready=0; completes on the cycle resp_ready rises.
- Reset mid-operation: assert rst_n=0 during SETTLE, asynchronously between clock edges -> all outputs return to reset values immediately; no response is produced; after release, a new req0 (42398284, 54389) -> quo=779, rem=29253.
